proc_fetch_resp_queue: RTL and testbench

- Sits between the instruction-memory response stream and the D-stage instruction register.
- Counts in-flight fetch requests and buffers fetch responses in a small circular queue.
- On a pipeline redirect, discards every response belonging to squashed requests, so the D stage only ever sees instructions from the redirected PC onward.
- Replaces the single-cycle drop signal with a counted drop that stays correct under multi-cycle memory latency.

---
 rtl/proc_fetch_resp_queue.sv | 94 +++++++++
 tb/tb_proc_fetch_resp_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/proc_fetch_resp_queue.sv
// Fetch response queue: tracks outstanding imem requests, buffers responses in a
// small circular queue and discards responses to requests squashed by a redirect.
module proc_fetch_resp_queue #(
  parameter int p_num_entries  = 2,
  parameter int p_max_inflight = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req_fire,
  output logic                                 req_ok,
  input  logic                                 resp_val,
  output logic                                 resp_rdy,
  input  logic [31:0]                          resp_data,
  input  logic                                 squash,
  output logic                                 deq_val,
  input  logic                                 deq_rdy,
  output logic [31:0]                          deq_data,
  output logic [$clog2(p_max_inflight+1)-1:0]  num_inflight
);

  localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int CW = $clog2(p_num_entries + 1);
  // One extra code point: the redirect-target request may issue while req_ok=0.
  localparam int IW = $clog2(p_max_inflight + 2);
  localparam int OW = $clog2(p_max_inflight + 1);

  logic [31:0]   mem_q [p_num_entries];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [IW-1:0] drop_q, drop_d;

  logic enq_fire, deq_fire, req_acc, resp_acc, write_en;

  assign req_ok       = inflight_q < IW'(p_max_inflight);
  assign resp_rdy     = (drop_q != '0) || (count_q != CW'(p_num_entries));
  assign deq_val      = (count_q != '0);
  assign deq_data     = mem_q[head_q];
  assign num_inflight = inflight_q[OW-1:0];

  assign enq_fire = resp_val && resp_rdy;
  assign deq_fire = deq_val && deq_rdy;
  assign req_acc  = req_fire && (req_ok || squash);
  assign resp_acc = enq_fire && (inflight_q != '0);
  assign write_en = resp_acc && !squash && (drop_q == '0);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + IW'(req_acc) - IW'(resp_acc);
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      drop_d  = inflight_q - IW'(resp_acc);
    end else begin
      if (deq_fire) head_d = head_q + PW'(1);
      if (write_en) tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(write_en) - CW'(deq_fire);
      drop_d  = drop_q - IW'(resp_acc && (drop_q != '0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      for (int i = 0; i < p_num_entries; i++) mem_q[i] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      if (write_en) mem_q[tail_q] <= resp_data;
    end
  end

`ifndef SYNTHESIS
  a_req_overflow: assert property (@(posedge clk) disable iff (reset)
    !(req_fire && !req_ok && !squash));
  a_resp_underflow: assert property (@(posedge clk) disable iff (reset)
    !(enq_fire && (inflight_q == '0)));
  a_drop_le_inflight: assert property (@(posedge clk) disable iff (reset)
    drop_q <= inflight_q);
`endif

endmodule

// File: tb/tb_proc_fetch_resp_queue.sv
// Directed bench for proc_fetch_resp_queue with a queue-level reference model
// compared every cycle, plus literal expectations on delivered words.
module tb_proc_fetch_resp_queue;

  localparam int N = 2;
  localparam int M = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_fire = 1'b0;
  logic        req_ok;
  logic        resp_val = 1'b0;
  logic        resp_rdy;
  logic [31:0] resp_data = '0;
  logic        squash = 1'b0;
  logic        deq_val;
  logic        deq_rdy = 1'b0;
  logic [31:0] deq_data;
  logic [$clog2(M+1)-1:0] num_inflight;

  proc_fetch_resp_queue #(.p_num_entries(N), .p_max_inflight(M)) dut (
    .clk(clk), .reset(reset), .req_fire(req_fire), .req_ok(req_ok),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .squash(squash), .deq_val(deq_val), .deq_rdy(deq_rdy),
    .deq_data(deq_data), .num_inflight(num_inflight)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Reference model: a word queue plus two plain integer counters.
  logic [31:0] m_q[$];
  int m_inflight = 0;
  int m_drop = 0;
  logic [31:0] log_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit m_rdy, enq, deqf, acc;
    m_rdy = (m_drop != 0) || (m_q.size() != N);
    enq   = resp_val && m_rdy;
    deqf  = (m_q.size() != 0) && deq_rdy;
    acc   = enq && (m_inflight > 0);
    if (reset) begin
      m_q.delete();
      m_inflight = 0;
      m_drop = 0;
    end else if (squash) begin
      m_drop = m_inflight - (acc ? 1 : 0);
      m_inflight = m_inflight + (req_fire ? 1 : 0) - (acc ? 1 : 0);
      m_q.delete();
    end else begin
      if (deqf) void'(m_q.pop_front());
      if (acc) begin
        if (m_drop > 0) m_drop--;
        else m_q.push_back(resp_data);
        m_inflight--;
      end
      if (req_fire && m_inflight < M + (acc ? 1 : 0)) m_inflight++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_deq_val", {31'b0, deq_val}, {31'b0, m_q.size() != 0});
      chk("cyc_resp_rdy", {31'b0, resp_rdy}, {31'b0, (m_drop != 0) || (m_q.size() != N)});
      chk("cyc_req_ok", {31'b0, req_ok}, {31'b0, m_inflight < M});
      chk("cyc_inflight", 32'(num_inflight), 32'(m_inflight));
      if (m_q.size() != 0) chk("cyc_deq_data", deq_data, m_q[0]);
      if (deq_val && deq_rdy && !squash) begin
        log_q.push_back(deq_data);
        $display("deq word=%h inflight=%0d", deq_data, num_inflight);
      end
    end
  end

  task automatic cyc(input bit rq, input bit rv, input logic [31:0] d,
                     input bit sq, input bit dr);
    req_fire = rq; resp_val = rv; resp_data = d; squash = sq; deq_rdy = dr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic chk_log(input string nm, input int n,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    chk({nm, "_len"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n && i < log_q.size(); i++) chk({nm, "_word"}, log_q[i], e[i]);
    log_q.delete();
  endtask

  initial begin
    do_reset();
    cmp_en = 1'b1;
    chk("rst_deq_val", {31'b0, deq_val}, 32'd0);
    chk("rst_resp_rdy", {31'b0, resp_rdy}, 32'd1);
    chk("rst_req_ok", {31'b0, req_ok}, 32'd1);
    chk("rst_inflight", 32'(num_inflight), 32'd0);
    chk("rst_deq_data", deq_data, 32'd0);

    // Back-to-back stream at one-cycle memory latency.
    cyc(1, 0, '0, 0, 1);            chk("t1_infl0", 32'(num_inflight), 32'd1);
    cyc(1, 1, 32'h00000013, 0, 1);  chk("t1_infl1", 32'(num_inflight), 32'd1);
    cyc(1, 1, 32'h00100093, 0, 1);  chk("t1_infl2", 32'(num_inflight), 32'd1);
    cyc(0, 1, 32'h00200113, 0, 1);  chk("t1_infl3", 32'(num_inflight), 32'd0);
    cyc(0, 0, '0, 0, 1);
    cyc(0, 0, '0, 0, 1);
    chk_log("t1_log", 3, 32'h00000013, 32'h00100093, 32'h00200113);

    // Backpressure: queue fills, third response stalls, pointers wrap.
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 1, 32'hA0000001, 0, 0);
    cyc(0, 1, 32'hA0000002, 0, 0);
    chk("t2_full_rdy", {31'b0, resp_rdy}, 32'd0);
    chk("t2_head", deq_data, 32'hA0000001);
    cyc(0, 1, 32'hA0000003, 0, 1);
    chk("t2_infl_stall", 32'(num_inflight), 32'd1);
    cyc(0, 1, 32'hA0000003, 0, 1);
    cyc(0, 0, '0, 0, 1);
    cyc(0, 0, '0, 0, 1);
    chk("t2_infl", 32'(num_inflight), 32'd0);
    chk_log("t2_log", 3, 32'hA0000001, 32'hA0000002, 32'hA0000003);

    // Squash with 4 outstanding and a same-cycle redirect request.
    for (int i = 0; i < 4; i++) cyc(1, 0, '0, 0, 1);
    chk("t3_req_ok", {31'b0, req_ok}, 32'd0);
    cyc(1, 0, '0, 1, 1);
    chk("t3_infl", 32'(num_inflight), 32'd5);
    chk("t3_deq_val", {31'b0, deq_val}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'hB0000000 + 32'(i), 0, 1);
    chk("t3_infl_left", 32'(num_inflight), 32'd1);
    cyc(0, 1, 32'hDEADBEEF, 0, 1);
    cyc(0, 0, '0, 0, 1);
    chk_log("t3_log", 1, 32'hDEADBEEF, '0, '0);

    // Squash coinciding with an accepted response, inflight=2.
    cyc(1, 0, '0, 0, 1);
    cyc(1, 0, '0, 0, 1);
    cyc(0, 1, 32'hC0000001, 1, 1);
    chk("t4_infl", 32'(num_inflight), 32'd1);
    cyc(0, 1, 32'hC0000002, 0, 1);
    cyc(0, 0, '0, 0, 1);
    chk("t4_infl_end", 32'(num_inflight), 32'd0);
    chk_log("t4_log", 0, '0, '0, '0);

    // Second squash while already dropping recomputes the drop count.
    cyc(1, 0, '0, 0, 1);
    cyc(1, 0, '0, 0, 1);
    cyc(1, 0, '0, 1, 1);
    cyc(0, 0, '0, 1, 1);
    chk("t5_infl", 32'(num_inflight), 32'd3);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'hD0000000 + 32'(i), 0, 1);
    cyc(1, 0, '0, 0, 1);
    cyc(0, 1, 32'hCAFE0001, 0, 1);
    cyc(0, 0, '0, 0, 1);
    chk_log("t5_log", 1, 32'hCAFE0001, '0, '0);

    // Reset mid-operation with two queued words and three outstanding requests.
    for (int i = 0; i < 4; i++) cyc(1, 0, '0, 0, 0);
    cyc(0, 1, 32'hE0000001, 0, 0);
    cyc(0, 1, 32'hE0000002, 0, 0);
    cyc(1, 0, '0, 0, 0);
    chk("t6_pre_infl", 32'(num_inflight), 32'd3);
    reset = 1'b1;
    cyc(0, 0, '0, 0, 0);
    reset = 1'b0;
    chk("t6_deq_val", {31'b0, deq_val}, 32'd0);
    chk("t6_resp_rdy", {31'b0, resp_rdy}, 32'd1);
    chk("t6_req_ok", {31'b0, req_ok}, 32'd1);
    chk("t6_infl", 32'(num_inflight), 32'd0);
    chk("t6_deq_data", deq_data, 32'd0);
    cyc(0, 0, '0, 0, 0);
    log_q.delete();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
